// File: rtl/transport_pkg.sv
// Shared encodings for the transport transmit path: session commands, frame types, FSM states,
// and the check-byte seed.
package transport_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_CTRL  = 2'b01,
        CMD_VOICE = 2'b10,
        CMD_FLUSH = 2'b11
    } cmd_e;

    localparam logic [1:0] TYPE_CTRL  = 2'b01;
    localparam logic [1:0] TYPE_VOICE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        HDR_DST,
        HDR_SRC,
        HDR_LEN,
        PAY_HI,
        PAY_LO,
        CHECK
    } state_e;

    localparam logic [7:0] CHK_INIT  = 8'h00;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One byte of CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/transport_if.sv
// Session command and PHY byte-stream signals of the transport transmitter.
// The master side is the session/PHY environment; the slave side is transport_tx.
interface transport_if;
    logic [1:0]  cmd;
    logic [15:0] dataOut;
    logic [7:0]  phoneOut;
    logic        transportBusy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        frame_done;

    modport master (
        output cmd, dataOut, phoneOut, tx_ready,
        input  transportBusy, tx_data, tx_valid, frame_done
    );

    modport slave (
        input  cmd, dataOut, phoneOut, tx_ready,
        output transportBusy, tx_data, tx_valid, frame_done
    );
endinterface

// File: rtl/transport_chk.sv
// Byte-serial frame check accumulator: mod-256 sum, or CRC-8/0x07 when TRANSPORT_CRC8_EN is defined.
// next_o is combinational (acc folded with byte_i); the accumulator updates only on byte_en_i.
module transport_chk
    import transport_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       byte_en_i,
    input  logic [7:0] byte_i,
    output logic [7:0] next_o
);
    logic [7:0] acc_q;

`ifdef TRANSPORT_CRC8_EN
    assign next_o = crc8_byte(acc_q, byte_i);
`else
    assign next_o = acc_q + byte_i;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= CHK_INIT;
        end else if (clr_i) begin
            acc_q <= CHK_INIT;
        end else if (byte_en_i) begin
            acc_q <= next_o;
        end
    end
endmodule

// File: rtl/transport_tx.sv
// Frames session control/voice words into addressed, checked byte streams (check byte selected by TRANSPORT_CRC8_EN).
// Byte0 valid one cycle after the last word is accepted; transportBusy stays high while streaming, bytes held on !tx_ready.
module transport_tx
    import transport_pkg::*;
#(
    parameter logic [7:0] MY_ADDR     = 8'h10,
    parameter int          VOICE_WORDS = 8
) (
    input logic        clk,
    input logic        reset,
    transport_if.slave bus
);
    localparam int         IDXW = (VOICE_WORDS > 1) ? $clog2(VOICE_WORDS) : 1;
    localparam logic [5:0] VW6  = 6'(VOICE_WORDS);

    state_e      state_q;
    logic [7:0]  dest_q;
    logic [7:0]  ctrl_dest_q;
    logic [15:0] ctrl_word_q;
    logic        ctrl_pending_q;
    logic [1:0]  type_q;
    logic [5:0]  len_q;
    logic [5:0]  count_q;
    logic [5:0]  widx_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic [15:0] buf_q [1 << IDXW];

    logic        accept_cmd;
    logic        xfer;
    logic [5:0]  count_d;
    logic [15:0] pay_word;
    logic        chk_clr;
    logic        chk_en;
    logic [7:0]  chk_next;

    assign accept_cmd = (bus.cmd != CMD_NONE) && !tx_valid_q;
    assign xfer       = tx_valid_q && bus.tx_ready;
    assign count_d    = count_q + 6'd1;
    assign pay_word   = (type_q == TYPE_CTRL) ? ctrl_word_q : buf_q[widx_q[IDXW-1:0]];

    // Accumulator idles at its seed outside a frame; the check byte is already latched by CHECK.
    assign chk_clr = !tx_valid_q || (state_q == CHECK);
    assign chk_en  = xfer && (state_q != CHECK);

    transport_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (chk_clr),
        .byte_en_i (chk_en),
        .byte_i    (tx_data_q),
        .next_o    (chk_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            dest_q         <= '0;
            ctrl_dest_q    <= '0;
            ctrl_word_q    <= '0;
            ctrl_pending_q <= 1'b0;
            type_q         <= '0;
            len_q          <= '0;
            count_q        <= '0;
            widx_q         <= '0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            for (int i = 0; i < (1 << IDXW); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE, COLLECT: begin
                    if (accept_cmd) begin
                        case (cmd_e'(bus.cmd))
                            CMD_CTRL: begin
                                ctrl_word_q <= bus.dataOut;
                                widx_q      <= '0;
                                tx_valid_q  <= 1'b1;
                                state_q     <= HDR_DST;
                                if (state_q == COLLECT) begin
                                    // Ship the partial voice frame first; the control frame follows from CHECK.
                                    ctrl_dest_q    <= bus.phoneOut;
                                    ctrl_pending_q <= 1'b1;
                                    type_q         <= TYPE_VOICE;
                                    len_q          <= count_q;
                                    tx_data_q      <= dest_q;
                                end else begin
                                    dest_q    <= bus.phoneOut;
                                    type_q    <= TYPE_CTRL;
                                    len_q     <= 6'd1;
                                    tx_data_q <= bus.phoneOut;
                                end
                            end
                            CMD_VOICE: begin
                                buf_q[count_q[IDXW-1:0]] <= bus.dataOut;
                                count_q                  <= count_d;
                                if (state_q == IDLE) begin
                                    dest_q <= bus.phoneOut;
                                end
                                if (count_d == VW6) begin
                                    type_q     <= TYPE_VOICE;
                                    len_q      <= count_d;
                                    tx_data_q  <= (state_q == IDLE) ? bus.phoneOut : dest_q;
                                    widx_q     <= '0;
                                    tx_valid_q <= 1'b1;
                                    state_q    <= HDR_DST;
                                end else begin
                                    state_q <= COLLECT;
                                end
                            end
                            CMD_FLUSH: begin
                                if (state_q == COLLECT) begin
                                    type_q     <= TYPE_VOICE;
                                    len_q      <= count_q;
                                    tx_data_q  <= dest_q;
                                    widx_q     <= '0;
                                    tx_valid_q <= 1'b1;
                                    state_q    <= HDR_DST;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                HDR_DST: if (xfer) begin
                    tx_data_q <= MY_ADDR;
                    state_q   <= HDR_SRC;
                end
                HDR_SRC: if (xfer) begin
                    tx_data_q <= {type_q, len_q};
                    state_q   <= HDR_LEN;
                end
                HDR_LEN: if (xfer) begin
                    tx_data_q <= pay_word[15:8];
                    state_q   <= PAY_HI;
                end
                PAY_HI: if (xfer) begin
                    tx_data_q <= pay_word[7:0];
                    widx_q    <= widx_q + 6'd1;
                    state_q   <= PAY_LO;
                end
                PAY_LO: if (xfer) begin
                    if (widx_q == len_q) begin
                        tx_data_q <= chk_next;
                        state_q   <= CHECK;
                    end else begin
                        tx_data_q <= pay_word[15:8];
                        state_q   <= PAY_HI;
                    end
                end
                CHECK: if (xfer) begin
                    count_q <= '0;
                    widx_q  <= '0;
                    if (ctrl_pending_q) begin
                        ctrl_pending_q <= 1'b0;
                        dest_q         <= ctrl_dest_q;
                        type_q         <= TYPE_CTRL;
                        len_q          <= 6'd1;
                        tx_data_q      <= ctrl_dest_q;
                        state_q        <= HDR_DST;
                    end else begin
                        tx_data_q  <= '0;
                        tx_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.transportBusy = tx_valid_q;
    assign bus.tx_valid      = tx_valid_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.frame_done    = xfer && (state_q == CHECK);
endmodule

// File: tb/tb_transport_tx.sv
// Randomized and directed bench for transport_tx against a frame-level reference model.
module tb_transport_tx;
    import transport_pkg::*;

    localparam logic [7:0] MYA = 8'h10;
    localparam int         VW  = 8;

    typedef logic [15:0] wq_t [$];
    typedef logic [7:0]  bq_t [$];

    logic clk = 1'b0;
    logic reset;
    transport_if bus ();

    transport_tx #(.MY_ADDR(MYA), .VOICE_WORDS(VW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] exp_q [$];
    logic       last_q [$];
    logic [7:0] got_q [$];
    wq_t        vq;
    logic [7:0] vdest;
    int         rdy_mode = 0;
    int         rdy_ph = 0;
    logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       stall_q = 1'b0;
    logic [7:0] held_q = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] frame_check(input bq_t fb);
        logic [7:0] r;
        int         s;
        logic       fbk;
        r = 8'h00;
        s = 0;
        fbk = 1'b0;
`ifdef TRANSPORT_CRC8_EN
        foreach (fb[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fbk = r[7] ^ fb[i][b];
                r   = {r[6:0], 1'b0};
                if (fbk) r = r ^ 8'h07;
            end
        end
`else
        foreach (fb[i]) s = s + int'(fb[i]);
        r = 8'(s % 256);
`endif
        return r;
    endfunction

    task automatic emit(input logic [1:0] ty, input logic [7:0] dst, input wq_t w);
        bq_t fb;
        fb.push_back(dst);
        fb.push_back(MYA);
        fb.push_back({ty, 6'(w.size())});
        foreach (w[i]) begin
            fb.push_back(w[i][15:8]);
            fb.push_back(w[i][7:0]);
        end
        fb.push_back(frame_check(fb));
        foreach (fb[i]) begin
            exp_q.push_back(fb[i]);
            last_q.push_back(i == fb.size() - 1);
        end
    endtask

    task automatic model_accept(input logic [1:0] c, input logic [15:0] d, input logic [7:0] p);
        wq_t one;
        case (c)
            2'b01: begin
                if (vq.size() > 0) begin
                    emit(2'b10, vdest, vq);
                    vq.delete();
                end
                one.push_back(d);
                emit(2'b01, p, one);
            end
            2'b10: begin
                if (vq.size() == 0) vdest = p;
                vq.push_back(d);
                if (vq.size() == VW) begin
                    emit(2'b10, vdest, vq);
                    vq.delete();
                end
            end
            2'b11: begin
                if (vq.size() > 0) begin
                    emit(2'b10, vdest, vq);
                    vq.delete();
                end
            end
            default: ;
        endcase
    endtask

    task automatic send(input logic [1:0] c, input logic [15:0] d, input logic [7:0] p);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        bus.cmd = c;
        bus.dataOut = d;
        bus.phoneOut = p;
        @(negedge clk);
        while (bus.transportBusy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("send_timeout", 32'd1, 32'd0);
        model_accept(c, d, p);
        @(posedge clk);
        #1;
        bus.cmd = 2'b00;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!bus.transportBusy) break;
            n++;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bus.tx_valid) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) chk("drain_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic ctrl_frame_check(input string tag);
        bq_t hdr;
        hdr = '{8'h20, 8'h10, 8'h41, 8'h30, 8'h05};
        chk({tag, "_len"}, got_q.size(), 6);
        foreach (hdr[i]) chk({tag, "_byte"}, got_q[i], hdr[i]);
        chk({tag, "_check"}, got_q[5], frame_check(hdr));
`ifndef TRANSPORT_CRC8_EN
        chk({tag, "_sum"}, got_q[5], 8'hA6);
`endif
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.tx_ready = 1'b1;
            1: bus.tx_ready = ($urandom_range(0, 3) != 0);
            default: begin
                bus.tx_ready = pat[rdy_ph];
                rdy_ph = (rdy_ph + 1) % 4;
            end
        endcase
    end

    always @(negedge clk) begin
        logic [7:0] e;
        logic       l;
        if (bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_byte", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                l = last_q.pop_front();
                chk("tx_data", bus.tx_data, e);
                chk("frame_done", bus.frame_done, l);
            end
            got_q.push_back(bus.tx_data);
        end else begin
            chk("frame_done_idle", bus.frame_done, 1'b0);
        end
        if (stall_q && bus.tx_valid) chk("stall_hold", bus.tx_data, held_q);
        stall_q = bus.tx_valid && !bus.tx_ready;
        held_q  = bus.tx_data;
    end

    initial begin
        int n;
        int r;
        reset = 1'b0;
        bus.cmd = 2'b00;
        bus.dataOut = '0;
        bus.phoneOut = '0;
        bus.tx_ready = 1'b1;
        #12;
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_busy", bus.transportBusy, 1'b0);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        @(posedge clk);
        #3 reset = 1'b1;

        // Single control frame
        got_q.delete();
        send(2'b01, 16'h3005, 8'h20);
        chk("ctrl_latency_vld", bus.tx_valid, 1'b1);
        chk("ctrl_latency_dst", bus.tx_data, 8'h20);
        count_busy(n);
        chk("ctrl_busy_cycles", n, 6);
        drain();
        ctrl_frame_check("ctrl");

        // Full voice frame; later phoneOut values must not replace the latched dest
        got_q.delete();
        for (int i = 1; i <= VW; i++) send(2'b10, 16'(i), (i == 1) ? 8'h20 : 8'h5A);
        drain();
        chk("voice_len", got_q.size(), 4 + 2 * VW);
        chk("voice_dst", got_q[0], 8'h20);
        chk("voice_byte2", got_q[2], 8'h88);
        chk("voice_w1_lo", got_q[4], 8'h01);
        chk("voice_w8_lo", got_q[18], 8'h08);
`ifndef TRANSPORT_CRC8_EN
        chk("voice_sum", got_q[19], 8'hDC);
`endif

        // Control preempts a partial voice frame, no gap between frames
        got_q.delete();
        send(2'b10, 16'h1111, 8'h20);
        send(2'b10, 16'h2222, 8'h20);
        send(2'b10, 16'h3333, 8'h20);
        send(2'b01, 16'hABCD, 8'h20);
        count_busy(n);
        chk("preempt_busy_cycles", n, 16);
        drain();
        chk("preempt_len", got_q.size(), 16);
        chk("preempt_byte2", got_q[2], 8'h83);
        chk("preempt_ctrl_dst", got_q[10], 8'h20);
        chk("preempt_ctrl_type", got_q[12], 8'h41);
        chk("preempt_ctrl_hi", got_q[13], 8'hAB);
        chk("preempt_ctrl_lo", got_q[14], 8'hCD);

        // Backpressure 1,0,0,1
        got_q.delete();
        rdy_mode = 2;
        rdy_ph = 0;
        send(2'b01, 16'h3005, 8'h20);
        drain();
        ctrl_frame_check("bp");
        rdy_mode = 0;

        // Flush in IDLE is a no-op; flush after two voice words
        got_q.delete();
        send(2'b11, 16'h0000, 8'h20);
        repeat (10) @(negedge clk);
        chk("flush_idle_bytes", got_q.size(), 0);
        chk("flush_idle_vld", bus.tx_valid, 1'b0);
        send(2'b10, 16'hBEEF, 8'h44);
        send(2'b10, 16'h0102, 8'h44);
        send(2'b11, 16'h0000, 8'h00);
        drain();
        chk("flush_len", got_q.size(), 8);
        chk("flush_byte2", got_q[2], 8'h82);

        // Async reset mid-payload
        for (int i = 1; i <= VW; i++) send(2'b10, 16'(i * 3), 8'h33);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        exp_q.delete();
        last_q.delete();
        vq.delete();
        #1;
        chk("arst_tx_valid", bus.tx_valid, 1'b0);
        chk("arst_busy", bus.transportBusy, 1'b0);
        chk("arst_frame_done", bus.frame_done, 1'b0);
        @(posedge clk);
        #3 reset = 1'b1;
        got_q.delete();
        send(2'b01, 16'h3005, 8'h20);
        drain();
        ctrl_frame_check("post_rst");

        // Randomized traffic under random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      send(2'b10, 16'($urandom), 8'($urandom));
            else if (r < 8) send(2'b01, 16'($urandom), 8'($urandom));
            else            send(2'b11, 16'($urandom), 8'($urandom));
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end
        send(2'b11, 16'h0000, 8'h00);
        drain();
        chk("rand_exp_empty", exp_q.size(), 0);
        rdy_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
